seq_mult_32bit: RTL

Multi-cycle unsigned 32×32→64-bit shift-and-add multiplier for the KGP-RISC execute stage. It sits directly upstream of `CLA_32bit_withLCU`: it instantiates one adder, drives its `in1`/`in2`/`c_in` every cycle and consumes `sum`/`c_out` as the partial-product update. A start/busy/done handshake lets the control unit stall on multiply instructions.

---
 rtl/seq_mult_32bit.sv | 101 ++++++++++
 1 files changed

// File: rtl/seq_mult_32bit.sv
// seq_mult_32bit: 32x32->64 unsigned shift-and-add multiplier built around a 32-bit CLA
module CLA_32bit_withLCU (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);
  logic [31:0] g, p;
  logic        bc, gg, pp, ck;
  assign g = in1 & in2;
  assign p = in1 ^ in2;
  // eight 4-bit lookahead groups; the group generate/propagate pairs form the carry unit chain
  always_comb begin
    sum = '0;
    bc = c_in;
    gg = 1'b0;
    pp = 1'b1;
    ck = 1'b0;
    for (int b = 0; b < 8; b++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int k = 0; k < 4; k++) begin
        gg = g[4*b+k] | (p[4*b+k] & gg);
        pp = pp & p[4*b+k];
      end
      ck = bc;
      for (int k = 0; k < 4; k++) begin
        sum[4*b+k] = p[4*b+k] ^ ck;
        ck = g[4*b+k] | (p[4*b+k] & ck);
      end
      bc = gg | (pp & bc);
    end
    c_out = bc;
  end
endmodule

module seq_mult_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod_hi,
  output logic [31:0] prod_lo
);
  localparam int WIDTH = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] m, a, q, sum;
  logic [5:0]       cnt;
  logic             c_out;
  CLA_32bit_withLCU u_cla (
    .in1  (a),
    .in2  (q[0] ? m : '0),
    .c_in (1'b0),
    .sum  (sum),
    .c_out(c_out)
  );
  assign prod_hi = a;
  assign prod_lo = q;
  // handshake FSM; each RUN step adds M when Q[0] is set and shifts {c_out,sum,Q} right by one
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m     <= '0;
      a     <= '0;
      q     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m     <= op_a;
          a     <= '0;
          q     <= op_b;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          {a, q} <= {c_out, sum, q[WIDTH-1:1]};
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
